// File: rtl/scroll_ctrl.sv
// ============================================================================
// Module   : scroll_ctrl
// Brief    : Frame-synchronous vertical-scroll sequencer producing a row
//            offset from run/direction/home buttons and a speed select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scroll_ctrl #(
    parameter int ROWS   = 240,
    parameter int H_LAST = 639,
    parameter int V_LAST = 479
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       btn_run,
    input  logic       btn_dir,
    input  logic       btn_home,
    input  logic [1:0] speed,
    output logic [7:0] offset,
    output logic       dir,
    output logic       scrolling,
    output logic       step_pulse,
    output logic       home_done
);

    localparam logic [7:0] c_ROW_LAST = 8'(ROWS - 1);
    localparam logic [7:0] c_ROW_HALF = 8'(ROWS / 2);
    localparam logic [9:0] c_H_LAST   = 10'(H_LAST);
    localparam logic [9:0] c_V_LAST   = 10'(V_LAST);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOME = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_offset, w_offset_nxt;
    logic [2:0] r_frame_cnt, w_frame_nxt;
    logic       r_dir, w_dir_nxt;
    logic       r_tick_d, r_step, r_home_done, r_scrolling;
    logic       w_tick, w_fev, w_step_nxt, w_home_done_nxt;
    logic [2:0] w_limit;
    logic [7:0] w_home_step;

    function automatic logic [7:0] f_step(input logic [7:0] cur, input logic down);
        if (down)
            return (cur == 8'd0) ? c_ROW_LAST : cur - 8'd1;
        else
            return (cur == c_ROW_LAST) ? 8'd0 : cur + 8'd1;
    endfunction

    // Edge-detect the last visible pixel so counters holding still give one event per frame
    assign w_tick      = (h_cnt == c_H_LAST) && (v_cnt == c_V_LAST);
    assign w_fev       = w_tick & ~r_tick_d;
    assign w_limit     = 3'((4'd1 << speed) - 4'd1);
    assign w_home_step = f_step(r_offset, r_offset < c_ROW_HALF);

    always_comb begin
        w_state_nxt     = r_state;
        w_offset_nxt    = r_offset;
        w_dir_nxt       = r_dir;
        w_frame_nxt     = r_frame_cnt;
        w_step_nxt      = 1'b0;
        w_home_done_nxt = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_fev) begin
                    if (r_frame_cnt >= w_limit) begin
                        w_offset_nxt = f_step(r_offset, r_dir);
                        w_step_nxt   = 1'b1;
                        w_frame_nxt  = 3'd0;
                    end else begin
                        w_frame_nxt = r_frame_cnt + 3'd1;
                    end
                end
            end
            ST_HOME: begin
                if (w_fev) begin
                    w_offset_nxt = w_home_step;
                    w_step_nxt   = 1'b1;
                    if (w_home_step == 8'd0) begin
                        w_state_nxt     = ST_STOP;
                        w_home_done_nxt = 1'b1;
                    end
                end
            end
            default: w_frame_nxt = 3'd0;
        endcase

        // Commands act on top of this cycle's step, which already used the old state/dir
        if (r_state != ST_HOME) begin
            if (btn_home) begin
                w_frame_nxt = 3'd0;
                if (w_offset_nxt != 8'd0) begin
                    w_state_nxt = ST_HOME;
                end else begin
                    w_state_nxt     = ST_STOP;
                    w_home_done_nxt = 1'b1;
                end
            end else if (btn_run) begin
                if (r_state == ST_RUN) begin
                    w_state_nxt = ST_STOP;
                    w_frame_nxt = 3'd0;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            if (btn_dir && (w_state_nxt != ST_HOME))
                w_dir_nxt = ~r_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_STOP;
            r_offset    <= 8'd0;
            r_dir       <= 1'b0;
            r_frame_cnt <= 3'd0;
            r_tick_d    <= 1'b0;
            r_step      <= 1'b0;
            r_home_done <= 1'b0;
            r_scrolling <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_offset    <= w_offset_nxt;
            r_dir       <= w_dir_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_tick_d    <= w_tick;
            r_step      <= w_step_nxt;
            r_home_done <= w_home_done_nxt;
            r_scrolling <= (w_state_nxt != ST_STOP);
        end
    end

    assign offset     = r_offset;
    assign dir        = r_dir;
    assign scrolling  = r_scrolling;
    assign step_pulse = r_step;
    assign home_done  = r_home_done;

endmodule

`default_nettype wire

// File: tb/tb_scroll_ctrl.sv
// ============================================================================
// Module   : tb_scroll_ctrl
// Brief    : Directed self-checking bench for scroll_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scroll_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] h_cnt, v_cnt;
    logic       btn_run, btn_dir, btn_home;
    logic [1:0] speed;
    logic [7:0] offset;
    logic       dir, scrolling, step_pulse, home_done;

    int total = 0;
    int bad   = 0;

    scroll_ctrl #(.ROWS(240), .H_LAST(639), .V_LAST(479)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .btn_run    (btn_run),
        .btn_dir    (btn_dir),
        .btn_home   (btn_home),
        .speed      (speed),
        .offset     (offset),
        .dir        (dir),
        .scrolling  (scrolling),
        .step_pulse (step_pulse),
        .home_done  (home_done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // One frame: counters parked at the last pixel for 'hold' clocks, then 2 idle clocks
    task automatic frame(input int hold, output int steps, output int hd, output int both);
        steps = 0; hd = 0; both = 0;
        h_cnt = 10'd639; v_cnt = 10'd479;
        for (int i = 0; i < hold + 2; i++) begin
            if (i == hold) begin
                h_cnt = 10'd0; v_cnt = 10'd0;
            end
            cyc();
            steps += int'(step_pulse);
            hd    += int'(home_done);
            both  += int'(step_pulse & home_done);
        end
    endtask

    task automatic press(input int which);
        if (which == 0) btn_run  = 1'b1;
        if (which == 1) btn_dir  = 1'b1;
        if (which == 2) btn_home = 1'b1;
        cyc();
        btn_run = 1'b0; btn_dir = 1'b0; btn_home = 1'b0;
    endtask

    task automatic frames(input int n);
        int s, h, b;
        for (int i = 0; i < n; i++) frame(1, s, h, b);
    endtask

    task automatic test_reset();
        int s, h, b, sum;
        do_reset();
        total++;
        if ({offset, dir, scrolling, step_pulse, home_done} !== 12'h000) begin
            bad++;
            $display("FAIL reset_state: got off=%0d dir=%0d scr=%0d stp=%0d hd=%0d, want all 0",
                     offset, dir, scrolling, step_pulse, home_done);
        end
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            frame(1, s, h, b);
            sum += s;
        end
        total++;
        if (sum != 0 || offset !== 8'd0 || scrolling !== 1'b0) begin
            bad++;
            $display("FAIL idle_frames: got steps=%0d off=%0d scr=%0d, want 0 0 0", sum, offset, scrolling);
        end
    endtask

    task automatic test_run_speed0();
        int s, h, b;
        do_reset();
        speed = 2'd0;
        press(0);
        total++;
        if (scrolling !== 1'b1) begin
            bad++;
            $display("FAIL run_scrolling: got %0d want 1", scrolling);
        end
        for (int k = 1; k <= 5; k++) begin
            frame(1, s, h, b);
            total++;
            if (offset !== 8'(k) || s != 1) begin
                bad++;
                $display("FAIL run_step%0d: got off=%0d steps=%0d, want off=%0d steps=1", k, offset, s, k);
            end
        end
        frame(4, s, h, b);
        total++;
        if (offset !== 8'd6 || s != 1) begin
            bad++;
            $display("FAIL held_counters: got off=%0d steps=%0d, want off=6 steps=1", offset, s);
        end
    endtask

    task automatic test_speed();
        int s, h, b;
        do_reset();
        speed = 2'd2;
        press(0);
        for (int f = 1; f <= 12; f++) begin
            frame(1, s, h, b);
            total++;
            if (s != ((f % 4 == 0) ? 1 : 0)) begin
                bad++;
                $display("FAIL speed2_frame%0d: got steps=%0d want %0d", f, s, (f % 4 == 0) ? 1 : 0);
            end
        end
        total++;
        if (offset !== 8'd3) begin
            bad++;
            $display("FAIL speed2_offset: got %0d want 3", offset);
        end
        frames(2);
        speed = 2'd0;
        frame(1, s, h, b);
        total++;
        if (offset !== 8'd4 || s != 1) begin
            bad++;
            $display("FAIL speed_drop: got off=%0d steps=%0d, want off=4 steps=1", offset, s);
        end
    endtask

    task automatic test_wrap();
        int s, h, b;
        do_reset();
        speed = 2'd0;
        press(1);
        press(0);
        frame(1, s, h, b);
        total++;
        if (offset !== 8'd239 || dir !== 1'b1) begin
            bad++;
            $display("FAIL wrap_down0: got off=%0d dir=%0d, want 239 1", offset, dir);
        end
        press(1);
        frame(1, s, h, b);
        total++;
        if (offset !== 8'd0) begin
            bad++;
            $display("FAIL wrap_up239: got %0d want 0", offset);
        end
        press(1);
        frame(1, s, h, b);
        total++;
        if (offset !== 8'd239) begin
            bad++;
            $display("FAIL wrap_dir_at0: got %0d want 239", offset);
        end
        // run/pause press landing on the frame event: step still happens, then stop
        btn_run = 1'b1; h_cnt = 10'd639; v_cnt = 10'd479;
        cyc();
        btn_run = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0;
        total++;
        if (offset !== 8'd238 || step_pulse !== 1'b1 || scrolling !== 1'b0) begin
            bad++;
            $display("FAIL run_on_fev: got off=%0d stp=%0d scr=%0d, want 238 1 0", offset, step_pulse, scrolling);
        end
        cyc();
        frame(1, s, h, b);
        total++;
        if (offset !== 8'd238 || s != 0) begin
            bad++;
            $display("FAIL stopped_after_fev: got off=%0d steps=%0d, want 238 0", offset, s);
        end
    endtask

    task automatic test_home();
        int s, h, b;
        do_reset();
        speed = 2'd0;
        press(0);
        frames(5);
        press(2);
        for (int k = 4; k >= 0; k--) begin
            frame(1, s, h, b);
            total++;
            if (offset !== 8'(k) || s != 1 || h != ((k == 0) ? 1 : 0) || b != h) begin
                bad++;
                $display("FAIL home_low_%0d: got off=%0d steps=%0d hd=%0d both=%0d, want off=%0d hd=%0d",
                         k, offset, s, h, b, k, (k == 0) ? 1 : 0);
            end
        end
        total++;
        if (scrolling !== 1'b0) begin
            bad++;
            $display("FAIL home_low_stop: got scr=%0d want 0", scrolling);
        end
        press(1);
        press(0);
        frames(40);
        press(0);
        total++;
        if (offset !== 8'd200 || scrolling !== 1'b0) begin
            bad++;
            $display("FAIL reach_200: got off=%0d scr=%0d, want 200 0", offset, scrolling);
        end
        press(2);
        press(0);
        total++;
        if (scrolling !== 1'b1) begin
            bad++;
            $display("FAIL home_ignores_run: got scr=%0d want 1", scrolling);
        end
        frames(39);
        total++;
        if (offset !== 8'd239 || home_done !== 1'b0) begin
            bad++;
            $display("FAIL home_high_239: got off=%0d hd=%0d, want 239 0", offset, home_done);
        end
        frame(1, s, h, b);
        total++;
        if (offset !== 8'd0 || b != 1 || scrolling !== 1'b0 || dir !== 1'b1) begin
            bad++;
            $display("FAIL home_high_wrap: got off=%0d both=%0d scr=%0d dir=%0d, want 0 1 0 1",
                     offset, b, scrolling, dir);
        end
    endtask

    task automatic test_reset_mid_home();
        int s, h, b;
        do_reset();
        speed = 2'd0;
        press(1);
        press(0);
        frames(140);
        press(2);
        frame(1, s, h, b);
        total++;
        if (offset !== 8'd99 || scrolling !== 1'b1) begin
            bad++;
            $display("FAIL home_from_100: got off=%0d scr=%0d, want 99 1", offset, scrolling);
        end
        rst_n = 1'b0;
        h_cnt = 10'd639; v_cnt = 10'd479;
        cyc();
        rst_n = 1'b1; h_cnt = 10'd0; v_cnt = 10'd0;
        total++;
        if (offset !== 8'd0 || scrolling !== 1'b0 || dir !== 1'b0 || step_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_home: got off=%0d scr=%0d dir=%0d stp=%0d, want 0 0 0 0",
                     offset, scrolling, dir, step_pulse);
        end
        press(2);
        total++;
        if (home_done !== 1'b1 || step_pulse !== 1'b0 || scrolling !== 1'b0) begin
            bad++;
            $display("FAIL home_at_zero: got hd=%0d stp=%0d scr=%0d, want 1 0 0", home_done, step_pulse, scrolling);
        end
        cyc();
        total++;
        if (home_done !== 1'b0) begin
            bad++;
            $display("FAIL home_done_width: got %0d want 0", home_done);
        end
    endtask

    initial begin
        rst_n = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0;
        btn_run = 1'b0; btn_dir = 1'b0; btn_home = 1'b0; speed = 2'd0;
        #1;
        test_reset();
        test_run_speed0();
        test_speed();
        test_wrap();
        test_home();
        test_reset_mid_home();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scroll_ctrl.md
Name: scroll_ctrl

Overview:
- Sequencing controller for the VGA vertical-scroll address generator.
- Turns debounced button pulses (run/pause, direction, home) and a speed select into a row offset 0..ROWS-1.
- Offset advances only at frame boundaries, detected from the VGA h_cnt/v_cnt, so the displayed image never tears.
- offset feeds the address generator's row-offset term; scrolling and step_pulse drive LEDs and status logic.

Parameters:
- ROWS, 240: number of source-image rows; offset wraps modulo ROWS.
- H_LAST, 639: last visible h_cnt value.
- V_LAST, 479: last visible v_cnt value.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- h_cnt  input  10  VGA horizontal counter; may hold a value for several clk cycles.
- v_cnt  input  10  VGA vertical counter.
- btn_run  input  1  one-cycle pulse; toggles run/pause.
- btn_dir  input  1  one-cycle pulse; toggles scroll direction.
- btn_home  input  1  one-cycle pulse; returns the image to offset 0.
- speed  input  2  frames per step = 1 << speed (1, 2, 4, 8).
- offset  output  8  current row offset, 0..ROWS-1.
- dir  output  1  0 = up (offset increments), 1 = down (offset decrements).
- scrolling  output  1  high when state != STOP.
- step_pulse  output  1  one-cycle pulse in the cycle offset takes a new value.
- home_done  output  1  one-cycle pulse when a home request completes.

Behaviour:
- Reset (rst_n low at a clk edge): state STOP, offset 0, dir 0, frame_cnt 0, tick_d 0, step_pulse 0, home_done 0, scrolling 0.
- Frame event:
  - tick = (h_cnt == H_LAST && v_cnt == V_LAST); tick_d is tick registered.
  - fev = tick & ~tick_d, so there is exactly one fev per frame however long the counters hold.
- States: STOP, RUN, HOME.
  - STOP: offset frozen; frame_cnt held at 0.
  - RUN, on fev:
    - if frame_cnt >= (1 << speed) - 1: step offset, clear frame_cnt.
    - else: increment frame_cnt.
    - Speed is sampled at each fev; lowering speed mid-count therefore steps at the next fev.
  - HOME, on fev: one row per frame, speed ignored.
    - offset < ROWS/2: decrement.
    - otherwise: increment, wrapping ROWS-1 -> 0.
    - The step that lands offset on 0 also sets state to STOP and pulses home_done in the same cycle as that step_pulse.
- Step arithmetic:
  - up: offset == ROWS-1 ? 0 : offset + 1.
  - down: offset == 0 ? ROWS-1 : offset - 1.
  - No out-of-range value is ever produced.
- Timing: offset and step_pulse update on the clk edge that samples fev (registered outputs, 1-cycle latency from the fev cycle), which falls inside blanking.
- Commands, sampled every cycle:
  - btn_home (STOP or RUN):
    - offset != 0: go to HOME; dir unchanged.
    - offset == 0: go to STOP and pulse home_done next cycle.
  - btn_run: STOP -> RUN; RUN -> STOP with frame_cnt cleared.
  - btn_dir: toggles dir in STOP and RUN.
  - In HOME, all three buttons are ignored.
- Simultaneous events:
  - btn_home has priority over btn_run in the same cycle; btn_dir is still applied unless the next state is HOME.
  - A command coinciding with fev: that cycle's step uses the pre-command state and dir. The command takes effect from the next cycle.
- Reset mid-operation (any state, including HOME) returns to reset values at the next edge; no pending step survives.
- scrolling is registered, equal to (next state != STOP).

Test Plan:
- Reset then 3 frames with no buttons -> offset 0, scrolling 0, no step_pulse.
- btn_run, speed=0, 5 frames -> offset 1,2,3,4,5, one step_pulse per frame, scrolling 1. Hold h_cnt/v_cnt at 639/479 for 4 clks -> exactly one step.
- speed=2, run for 12 frames from offset 0 -> steps on frames 4, 8, 12, offset 3. Switch speed to 0 with frame_cnt=2 -> step at next fev.
- Wrap: offset 239, dir 0 -> next step 0. btn_dir at offset 0 -> next step 239. btn_run and fev in same cycle -> step still occurs, then STOP.
- btn_home at offset 5 -> offsets 4,3,2,1,0 on successive frames; home_done with the final step; state STOP. At offset 200 -> increments 201..239, 0 (40 frames). btn_run during HOME ignored.
- rst_n low during HOME at offset 100 -> next edge offset 0, STOP, dir 0. btn_home at offset 0 -> home_done pulse, no step_pulse.
